// File: rtl/regfile_wb_arbiter_if.sv
// Write-back request channel: one requester's valid/ready handshake.
// Ports: valid, rd (dest index), data in; ready back to the requester.
interface regfile_wb_arbiter_if #(
  parameter int ARCH_LEN     = 32,
  parameter int REG_FILE_LEN = 32
);
  localparam int RW = $clog2(REG_FILE_LEN);

  logic                valid;
  logic [RW-1:0]       rd;
  logic [ARCH_LEN-1:0] data;
  logic                ready;

  modport master (
    output valid,
    output rd,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  rd,
    input  data,
    output ready
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the register-file write port between ALU (wb0) and load (wb1).
// Ports: clk, rst, wb0/wb1 slave channels; registered dst_reg/data/we, wb_src.
package constants_pkg;
  localparam int ARCH_LEN     = 32;
  localparam int REG_FILE_LEN = 32;
endpackage

module regfile_wb_arbiter #(
  parameter int ARCH_LEN     = constants_pkg::ARCH_LEN,
  parameter int REG_FILE_LEN = constants_pkg::REG_FILE_LEN,
  parameter int MAX_WAIT     = 3,
  localparam int RW          = $clog2(REG_FILE_LEN)
) (
  input  logic                clk,
  input  logic                rst,
  regfile_wb_arbiter_if.slave wb0,
  regfile_wb_arbiter_if.slave wb1,
  output logic [RW-1:0]       dst_reg,
  output logic [ARCH_LEN-1:0] dst_reg_data,
  output logic                reg_write_enable,
  output logic                wb_src
);

  localparam logic [3:0] MW = 4'(MAX_WAIT);

  logic [3:0]          wait_cnt_q, wait_cnt_d;
  logic [RW-1:0]       dst_reg_q, dst_reg_d;
  logic [ARCH_LEN-1:0] dst_data_q, dst_data_d;
  logic                we_q, we_d;
  logic                src_q, src_d;

  logic force1;
  logic rdy0, rdy1;
  logic xfer0, xfer1;

  // force1 flips priority so wb1 cannot be starved past MAX_WAIT refusals
  assign force1 = (wait_cnt_q == MW);
  assign rdy1   = !rst && (force1 || !wb0.valid);
  assign rdy0   = !rst && !(force1 && wb1.valid);
  assign xfer0  = wb0.valid && rdy0;
  assign xfer1  = wb1.valid && rdy1;

  assign wb0.ready = rdy0;
  assign wb1.ready = rdy1;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (xfer1 || !wb1.valid) begin
      wait_cnt_d = '0;
    end else if (!force1) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end
  end

  // x0 writes are accepted but never enabled
  always_comb begin
    dst_reg_d  = dst_reg_q;
    dst_data_d = dst_data_q;
    src_d      = src_q;
    we_d       = 1'b0;
    unique case (1'b1)
      xfer0: begin
        dst_reg_d  = wb0.rd;
        dst_data_d = wb0.data;
        src_d      = 1'b0;
        we_d       = (wb0.rd != '0);
      end
      xfer1: begin
        dst_reg_d  = wb1.rd;
        dst_data_d = wb1.data;
        src_d      = 1'b1;
        we_d       = (wb1.rd != '0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q <= '0;
      dst_reg_q  <= '0;
      dst_data_q <= '0;
      we_q       <= 1'b0;
      src_q      <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      dst_reg_q  <= dst_reg_d;
      dst_data_q <= dst_data_d;
      we_q       <= we_d;
      src_q      <= src_d;
    end
  end

  assign dst_reg          = dst_reg_q;
  assign dst_reg_data     = dst_data_q;
  assign reg_write_enable = we_q;
  assign wb_src           = src_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized + directed bench for regfile_wb_arbiter.
// Model tracks wb1's refusal streak and the expected registered write.
module tb_regfile_wb_arbiter;

  localparam int MAX_WAIT = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  dst_reg;
  logic [31:0] dst_reg_data;
  logic        reg_write_enable;
  logic        wb_src;

  regfile_wb_arbiter_if #(.ARCH_LEN(32), .REG_FILE_LEN(32)) wb0 ();
  regfile_wb_arbiter_if #(.ARCH_LEN(32), .REG_FILE_LEN(32)) wb1 ();

  regfile_wb_arbiter #(
    .ARCH_LEN(32),
    .REG_FILE_LEN(32),
    .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .wb0(wb0.slave),
    .wb1(wb1.slave),
    .dst_reg(dst_reg),
    .dst_reg_data(dst_reg_data),
    .reg_write_enable(reg_write_enable),
    .wb_src(wb_src)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  int          streak = 0;
  logic        m_we = 0;
  logic [4:0]  m_dst = 0;
  logic [31:0] m_data = 0;
  logic        m_src = 0;
  logic        last_r0, last_r1;

  logic [31:0] rf_dut [32];

  always @(posedge clk) begin
    if (reg_write_enable) rf_dut[dst_reg] <= dst_reg_data;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic rs,
                      input logic a0, input logic [4:0] ra,
                      input logic [31:0] da,
                      input logic a1, input logic [4:0] rb,
                      input logic [31:0] db);
    logic f, er0, er1, t0, t1;
    @(negedge clk);
    rst = rs;
    wb0.valid = a0; wb0.rd = ra; wb0.data = da;
    wb1.valid = a1; wb1.rd = rb; wb1.data = db;
    #1;
    f   = (streak >= MAX_WAIT);
    er0 = !rs && !(f && a1);
    er1 = !rs && (f || !a0);
    last_r0 = wb0.ready;
    last_r1 = wb1.ready;
    chk("wb0_ready", 32'(wb0.ready), 32'(er0));
    chk("wb1_ready", 32'(wb1.ready), 32'(er1));
    t0 = a0 && er0;
    t1 = a1 && er1;
    if (rs) begin
      streak = 0;
      m_we = 0; m_dst = 0; m_data = 0; m_src = 0;
    end else begin
      if (t0) begin
        m_dst = ra; m_data = da; m_src = 0; m_we = (ra != 0);
      end else if (t1) begin
        m_dst = rb; m_data = db; m_src = 1; m_we = (rb != 0);
      end else begin
        m_we = 0;
      end
      if (t1 || !a1) streak = 0;
      else if (streak < MAX_WAIT) streak++;
    end
    @(posedge clk);
    #1;
    chk("we", 32'(reg_write_enable), 32'(m_we));
    chk("dst_reg", 32'(dst_reg), 32'(m_dst));
    chk("dst_data", dst_reg_data, m_data);
    chk("wb_src", 32'(wb_src), 32'(m_src));
  endtask

  initial begin
    logic        v0, v1;
    logic [4:0]  r0, r1;
    logic [31:0] d0, d1;

    rst = 1'b1;
    wb0.valid = 0; wb0.rd = 0; wb0.data = 0;
    wb1.valid = 0; wb1.rd = 0; wb1.data = 0;

    // reset with both valid
    step(1, 1, 5'd4, 32'h11, 1, 5'd6, 32'h22);
    step(1, 1, 5'd4, 32'h11, 1, 5'd6, 32'h22);
    chk("rst_r0", 32'(last_r0), 32'd0);
    chk("rst_r1", 32'(last_r1), 32'd0);
    chk("rst_we", 32'(reg_write_enable), 32'd0);
    chk("rst_data", dst_reg_data, 32'd0);
    step(0, 1, 5'd4, 32'h11, 0, 5'd0, 32'h0);
    chk("rel_src", 32'(wb_src), 32'd0);
    chk("rel_dst", 32'(dst_reg), 32'd4);

    // single requester 1
    step(0, 0, 5'd0, 32'h0, 1, 5'd5, 32'hDEADBEEF);
    chk("single_r1", 32'(last_r1), 32'd1);
    chk("single_dst", 32'(dst_reg), 32'd5);
    chk("single_data", dst_reg_data, 32'hDEADBEEF);
    chk("single_src", 32'(wb_src), 32'd1);

    // contention: wb1 goes through on cycle 4
    step(1, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 5'(8 + i), 32'h100 + i, (i <= 3), 5'd9, 32'h5A5A);
      chk("cont_r0", 32'(last_r0), 32'(i != 3));
      chk("cont_src", 32'(wb_src), 32'(i == 3));
    end

    // x0 write
    step(0, 1, 5'd0, 32'h1234, 0, 5'd0, 32'h0);
    chk("x0_r0", 32'(last_r0), 32'd1);
    chk("x0_we", 32'(reg_write_enable), 32'd0);

    // back-to-back
    step(0, 1, 5'd1, 32'hA, 0, 5'd0, 32'h0);
    chk("b2b_1", dst_reg_data, 32'hA);
    step(0, 1, 5'd2, 32'hB, 0, 5'd0, 32'h0);
    chk("b2b_2", dst_reg_data, 32'hB);
    step(0, 1, 5'd3, 32'hC, 0, 5'd0, 32'h0);
    chk("b2b_3", dst_reg_data, 32'hC);
    step(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    chk("rf1", rf_dut[1], 32'hA);
    chk("rf2", rf_dut[2], 32'hB);
    chk("rf3", rf_dut[3], 32'hC);

    // reset mid-stall restarts the wait
    step(0, 1, 5'd10, 32'h1, 1, 5'd11, 32'h77);
    step(0, 1, 5'd10, 32'h2, 1, 5'd11, 32'h77);
    step(1, 1, 5'd10, 32'h3, 1, 5'd11, 32'h77);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 5'd12, 32'h40 + i, 1, 5'd11, 32'h77);
      chk("mid_r1", 32'(last_r1), 32'(i == 3));
    end

    // randomized traffic; requesters hold until accepted
    v0 = 0; v1 = 0; r0 = 0; r1 = 0; d0 = 0; d1 = 0;
    for (int n = 0; n < 400; n++) begin
      logic rs;
      rs = ($urandom_range(0, 49) == 0);
      if (!v0) begin
        v0 = ($urandom_range(0, 3) != 0);
        r0 = 5'($urandom_range(0, 31));
        d0 = $urandom;
      end
      if (!v1) begin
        v1 = ($urandom_range(0, 2) != 0);
        r1 = 5'($urandom_range(0, 31));
        d1 = $urandom;
      end
      step(rs, v0, r0, d0, v1, r1, d1);
      if (v0 && last_r0) v0 = 0;
      if (v1 && last_r1) v1 = 0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
